lcd_sync_monitor: RTL and testbench
===================================

// Module: lcd_sync_monitor
// PURPOSE
//  Receive-side checker for the 480x272 LCD video interface driven by the board renderer (BGR/HSYNC/VSYNC/DISP).
//  Locks to the sync pulses, rebuilds pixel coordinates, flags timing violations and captures one probe pixel per frame.
//  Sits beside the panel on the same clk12 domain; used for on-chip self-test and as the bench scoreboard front end.
// PARAMETERS
//  H_TOTAL      526  clocks between consecutive HSYNC rising edges
//  V_TOTAL      286  HSYNC rises between consecutive VSYNC rising edges
//  H_ACTIVE     480  active pixels per line
//  V_ACTIVE     272  active lines per frame
//  H_OFFSET     43   clocks from HSYNC rise to pixel x=0 (first sample is the H_OFFSET-th clock after the rise)
//  V_OFFSET     13   HSYNC rise count after a VSYNC rise that precedes row y=0
//  LOCK_FRAMES  2    consecutive clean frames needed to assert locked
//  PROBE_X      0    probe pixel column;  PROBE_Y 0  probe pixel row
// PORTS
//  clk12      in   1   pixel clock
//  reset      in   1   asynchronous, active-high reset
//  HSYNC      in   1   line sync, active high, 1 clock wide
//  VSYNC      in   1   frame sync, active high, one line wide
//  DISP       in   1   display enable
//  BGR        in   24  pixel data {B,G,R}
//  locked     out  1   timing lock achieved
//  pix_x      out  9   current column (valid while pix_valid)
//  pix_y      out  9   current row (valid while pix_valid)
//  pix_valid  out  1   BGR on this cycle is an active pixel (locked only)
//  probe_bgr  out  24  BGR captured at (PROBE_X,PROBE_Y)
//  probe_stb  out  1   1-cycle pulse, cycle after probe_bgr updates
//  frame_stb  out  1   1-cycle pulse on every VSYNC rise while locked
//  h_err      out  1   1-cycle pulse: HSYNC period != H_TOTAL
//  v_err      out  1   1-cycle pulse: line count != V_TOTAL, or DISP low while locked
//  err_count  out  8   saturating count of h_err|v_err pulses (saturates at 255)
// BEHAVIOUR
//  - Reset: all outputs 0, state SEARCH, counters 0; reset mid-frame discards lock and all partial measurements.
//  - Edge detect: HSYNC/VSYNC registered once; rise = cur & ~prev. All outputs registered, 1-clock latency from input.
//  - hcnt: clears to 1 on HSYNC rise, else increments, saturates at 1023. period = hcnt at next rise.
//  - vcnt: clears to 0 on VSYNC rise, increments on each HSYNC rise; row y = vcnt - V_OFFSET.
//  - x = hcnt - H_OFFSET; pix_valid = locked & 0<=x<H_ACTIVE & 0<=y<V_ACTIVE.
//  - FSM: SEARCH: wait VSYNC rise -> TRAIN, good=0.
//    TRAIN: every HSYNC rise checks period (first rise after entry not checked); every VSYNC rise checks vcnt;
//      any mismatch -> good=0, stay TRAIN; clean VSYNC rise -> good+1; good==LOCK_FRAMES -> LOCKED, locked=1 next cycle.
//    LOCKED: mismatch or DISP=0 -> h_err/v_err pulse, err_count+1, SEARCH, locked=0 next cycle.
//  - Errors only reported in LOCKED; TRAIN mismatches are silent.
//  - Simultaneous HSYNC and VSYNC rise: HSYNC check first, then VSYNC; vcnt becomes 0 (rise not counted to new frame).
//  - Missing HSYNC: hcnt reaching H_TOTAL+1 without a rise counts as h_err immediately (no wait for next rise).
//  - Probe: when pix_valid & x==PROBE_X & y==PROBE_Y, probe_bgr<=BGR; probe_stb next cycle. Held until next capture.
// CONFIGURATION
//  MON_FRAME_SIG_EN defined: adds output frame_sig[23:0]; accumulator sig<=(sig<<<1)^BGR over pix_valid pixels,
//    cleared at VSYNC rise; frame_sig loads the completed value on that rise (same cycle as frame_stb). Reset 0.
//  Undefined: port and accumulator absent; all other behaviour identical.
// TESTING
//  1 Nominal generator (526x286, HSYNC at h=483, VSYNC v=273) -> locked=1 right after 2nd clean VSYNC rise; err_count=0.
//  2 Solid 24'h11448B frame, probe (0,0) -> probe_bgr=24'h11448B, one probe_stb per frame; pix_x 0..479 per row.
//  3 Locked, one line stretched to 527 clocks -> one h_err pulse, locked=0, err_count=1, relock after 2 clean frames.
//  4 Locked, frame of 285 lines -> v_err pulse at VSYNC rise, state SEARCH; DISP forced 0 -> v_err, err_count=2.
//  5 Reset asserted at row 100 then released -> all outputs 0 immediately; locked=0 until 2 new clean frames.
//  6 MON_FRAME_SIG_EN, all-zero frame -> frame_sig=0; single pixel 24'h000001 at (479,271) -> frame_sig=24'h000001.

Source files
------------

// File: rtl/lcd_sync_monitor.sv
// Receive-side timing checker for the LCD HSYNC/VSYNC/DISP/BGR interface on clk12.
// Define MON_FRAME_SIG_EN to add the frame_sig output (per-frame pixel signature).
module lcd_sync_monitor #(
    parameter int H_TOTAL     = 526,
    parameter int V_TOTAL     = 286,
    parameter int H_ACTIVE    = 480,
    parameter int V_ACTIVE    = 272,
    parameter int H_OFFSET    = 43,
    parameter int V_OFFSET    = 13,
    parameter int LOCK_FRAMES = 2,
    parameter int PROBE_X     = 0,
    parameter int PROBE_Y     = 0
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic        DISP,
    input  logic [23:0] BGR,
    output logic        locked,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_valid,
    output logic [23:0] probe_bgr,
    output logic        probe_stb,
    output logic        frame_stb,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_count
`ifdef MON_FRAME_SIG_EN
    ,
    output logic [23:0] frame_sig
`endif
);

    localparam logic [9:0]         HT_C  = 10'(H_TOTAL);
    localparam logic [9:0]         HT1_C = 10'(H_TOTAL + 1);
    localparam logic [9:0]         VT_C  = 10'(V_TOTAL);
    localparam logic signed [10:0] HO_S  = 11'(H_OFFSET);
    localparam logic signed [10:0] VO_S  = 11'(V_OFFSET);
    localparam logic signed [10:0] HA_S  = 11'(H_ACTIVE);
    localparam logic signed [10:0] VA_S  = 11'(V_ACTIVE);
    localparam logic signed [10:0] PX_S  = 11'(PROBE_X);
    localparam logic signed [10:0] PY_S  = 11'(PROBE_Y);
    localparam logic [3:0]         LF_C  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t             state;
    logic               hs_p0, vs_p0;
    logic [9:0]         hcnt, vcnt;
    logic [3:0]         good;
    logic               skip_h;
    logic               hit_p1;
    logic               hrise, vrise, h_bad, v_bad, act, hit;
    logic signed [10:0] x_s, y_s;

    assign hrise = HSYNC & ~hs_p0;
    assign vrise = VSYNC & ~vs_p0;
    assign x_s   = $signed({1'b0, hcnt}) - HO_S;
    assign y_s   = $signed({1'b0, vcnt}) - VO_S;
    assign act   = (state == LOCKED) && (x_s >= 11'sd0) && (x_s < HA_S)
                   && (y_s >= 11'sd0) && (y_s < VA_S);
    assign hit   = act && (x_s == PX_S) && (y_s == PY_S);
    // A line that runs one clock past nominal is already wrong; flag it without waiting for HSYNC.
    assign h_bad = hrise ? (hcnt != HT_C) : (hcnt == HT1_C);
    // The HSYNC rise coincident with VSYNC closes the old frame, so it joins the line tally here.
    assign v_bad = vrise && ((vcnt + {9'd0, hrise}) != VT_C);

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            hs_p0     <= 1'b0;
            vs_p0     <= 1'b0;
            hcnt      <= '0;
            vcnt      <= '0;
            good      <= '0;
            skip_h    <= 1'b0;
            hit_p1    <= 1'b0;
            locked    <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b0;
            probe_bgr <= '0;
            probe_stb <= 1'b0;
            frame_stb <= 1'b0;
            h_err     <= 1'b0;
            v_err     <= 1'b0;
            err_count <= '0;
        end else begin
            // p0: sync edge history and position counters
            hs_p0 <= HSYNC;
            vs_p0 <= VSYNC;
            hcnt  <= hrise ? 10'd1 : sat_inc10(hcnt);
            if (vrise)
                vcnt <= '0;
            else if (hrise)
                vcnt <= sat_inc10(vcnt);

            pix_valid <= act;
            pix_x     <= act ? x_s[8:0] : 9'd0;
            pix_y     <= act ? y_s[8:0] : 9'd0;
            if (hit)
                probe_bgr <= BGR;
            // p1: strobe trails the probe capture by one cycle
            hit_p1    <= hit;
            probe_stb <= hit_p1;
            frame_stb <= (state == LOCKED) && vrise;
            h_err     <= 1'b0;
            v_err     <= 1'b0;

            case (state)
                SEARCH: begin
                    if (vrise) begin
                        state  <= TRAIN;
                        good   <= '0;
                        skip_h <= 1'b1;
                    end
                end
                TRAIN: begin
                    if (hrise)
                        skip_h <= 1'b0;
                    if ((h_bad && !skip_h) || v_bad) begin
                        good <= '0;
                    end else if (vrise) begin
                        good <= good + 4'd1;
                        if (good + 4'd1 == LF_C) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (h_bad || v_bad || !DISP) begin
                        h_err     <= h_bad;
                        v_err     <= v_bad || !DISP;
                        err_count <= sat_inc8(err_count);
                        state     <= SEARCH;
                        locked    <= 1'b0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

`ifdef MON_FRAME_SIG_EN
    logic [23:0] sig_acc;

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            sig_acc   <= '0;
            frame_sig <= '0;
        end else if (vrise) begin
            sig_acc <= '0;
            if (state == LOCKED)
                frame_sig <= sig_acc;
        end else if (act) begin
            sig_acc <= (sig_acc <<< 1) ^ BGR;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_sync_monitor.sv
// Randomized bench for lcd_sync_monitor on a reduced raster, checked against a timestamp-based model.
module tb_lcd_sync_monitor;

    localparam int HT = 20, VT = 12, HA = 8, VA = 6, HO = 5, VO = 3, LF = 2, PX = 3, PY = 2;

    logic        clk12 = 1'b0;
    logic        reset, HSYNC, VSYNC, DISP;
    logic [23:0] BGR;
    logic        locked, pix_valid, probe_stb, frame_stb, h_err, v_err;
    logic [8:0]  pix_x, pix_y;
    logic [23:0] probe_bgr;
    logic [7:0]  err_count;
`ifdef MON_FRAME_SIG_EN
    logic [23:0] frame_sig;
`endif

    int vectors = 0, miscompares = 0;
    int cnt_valid, cnt_probe, cnt_frame, cnt_herr, cnt_verr;
    logic [79:0] obs_vec, exp_vec, bad_obs, bad_exp;

    // reference model state
    int   m_t, m_last_h, m_lines, m_mode, m_good;
    bit   m_skip, m_phs, m_pvs, m_hit_prev;
    logic [23:0] m_sig;
    logic        e_locked, e_pix_valid, e_probe_stb, e_frame_stb, e_h_err, e_v_err;
    logic [8:0]  e_pix_x, e_pix_y;
    logic [23:0] e_probe_bgr, e_frame_sig;
    logic [7:0]  e_err_count;

    always #5 clk12 = ~clk12;

    lcd_sync_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_OFFSET(HO),
        .V_OFFSET(VO), .LOCK_FRAMES(LF), .PROBE_X(PX), .PROBE_Y(PY)
    ) dut (
        .clk12(clk12), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC), .DISP(DISP), .BGR(BGR),
        .locked(locked), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .probe_bgr(probe_bgr), .probe_stb(probe_stb), .frame_stb(frame_stb),
        .h_err(h_err), .v_err(v_err), .err_count(err_count)
`ifdef MON_FRAME_SIG_EN
        , .frame_sig(frame_sig)
`endif
    );

`ifdef MON_FRAME_SIG_EN
    assign obs_vec = {locked, pix_valid, pix_x, pix_y, probe_bgr, probe_stb, frame_stb, h_err, v_err, err_count, frame_sig};
`else
    assign obs_vec = {locked, pix_valid, pix_x, pix_y, probe_bgr, probe_stb, frame_stb, h_err, v_err, err_count, 24'd0};
`endif
    assign exp_vec = {e_locked, e_pix_valid, e_pix_x, e_pix_y, e_probe_bgr, e_probe_stb, e_frame_stb,
                      e_h_err, e_v_err, e_err_count, e_frame_sig};

    task automatic model_reset();
        m_t = 0; m_last_h = 0; m_lines = 0; m_mode = 0; m_good = 0;
        m_skip = 0; m_phs = 0; m_pvs = 0; m_hit_prev = 0; m_sig = 0;
        e_locked = 0; e_pix_valid = 0; e_probe_stb = 0; e_frame_stb = 0; e_h_err = 0; e_v_err = 0;
        e_pix_x = 0; e_pix_y = 0; e_probe_bgr = 0; e_frame_sig = 0; e_err_count = 0;
    endtask

    // Expected outputs after one clock, from clocks since last HSYNC rise and lines since last VSYNC rise.
    task automatic model_edge(input bit hs, input bit vs, input bit disp, input logic [23:0] bgr);
        bit hr, vr, hb, vb, act, hit;
        int age, x, y;
        hr  = hs && !m_phs;
        vr  = vs && !m_pvs;
        age = m_t - m_last_h;
        if (age > 1023) age = 1023;
        x   = age - HO;
        y   = m_lines - VO;
        act = (m_mode == 2) && x >= 0 && x < HA && y >= 0 && y < VA;
        hit = act && x == PX && y == PY;
        hb  = hr ? (age != HT) : (age == HT + 1);
        vb  = vr && (m_lines + int'(hr) != VT);

        e_pix_valid = act;
        e_pix_x     = act ? 9'(x) : 9'd0;
        e_pix_y     = act ? 9'(y) : 9'd0;
        if (hit) e_probe_bgr = bgr;
        e_probe_stb = m_hit_prev;
        m_hit_prev  = hit;
        e_frame_stb = (m_mode == 2) && vr;
        e_h_err = 0;
        e_v_err = 0;
        if (vr) begin
            if (m_mode == 2) e_frame_sig = m_sig;
            m_sig = 0;
        end else if (act) begin
            m_sig = {m_sig[22:0], 1'b0} ^ bgr;
        end
`ifndef MON_FRAME_SIG_EN
        e_frame_sig = 0;
`endif

        case (m_mode)
            0: if (vr) begin m_mode = 1; m_good = 0; m_skip = 1; end
            1: begin
                if ((hb && !m_skip) || vb) m_good = 0;
                else if (vr) begin
                    m_good++;
                    if (m_good == LF) m_mode = 2;
                end
                if (hr) m_skip = 0;
            end
            default: if (hb || vb || !disp) begin
                e_h_err = hb;
                e_v_err = vb || !disp;
                if (e_err_count != 8'd255) e_err_count = e_err_count + 8'd1;
                m_mode = 0;
            end
        endcase
        e_locked = (m_mode == 2);

        if (hr) m_last_h = m_t;
        if (vr) m_lines = 0;
        else if (hr && m_lines < 1023) m_lines++;
        m_phs = hs;
        m_pvs = vs;
        m_t++;
    endtask

    task automatic clear_tally();
        cnt_valid = 0; cnt_probe = 0; cnt_frame = 0; cnt_herr = 0; cnt_verr = 0;
    endtask

    task automatic cycle(input bit hs, input bit vs, input bit disp, input logic [23:0] bgr);
        HSYNC = hs; VSYNC = vs; DISP = disp; BGR = bgr;
        @(posedge clk12);
        model_edge(hs, vs, disp, bgr);
        #1;
        cnt_valid += int'(pix_valid);
        cnt_probe += int'(probe_stb);
        cnt_frame += int'(frame_stb);
        cnt_herr  += int'(h_err);
        cnt_verr  += int'(v_err);
    endtask

    // pat: 0 random, 1 solid 11448B, 2 all zero, 3 single 000001 at the last active pixel
    task automatic run_frame(input int nlines, input int long_line, input int long_len,
                             input bit disp, input int pat, output int bad);
        bad = 0;
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == long_line) ? long_len : HT;
            for (int h = 0; h < len; h++) begin
                logic [23:0] px;
                case (pat)
                    0:       px = 24'($urandom);
                    1:       px = 24'h11448B;
                    2:       px = 24'h0;
                    default: px = (l == VO + VA - 1 && h == HO + HA - 1) ? 24'h000001 : 24'h0;
                endcase
                cycle(h == 0, l == 0, disp, px);
                if (obs_vec !== exp_vec) begin
                    if (bad == 0) begin bad_obs = obs_vec; bad_exp = exp_vec; end
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (obs_vec !== 80'd0) begin miscompares++; $display("FAIL reset_state: got %h want 0", obs_vec); end
        @(negedge clk12);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 24'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL reset_idle%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
    endtask

    task automatic relock(input string tag);
        int bad;
        for (int f = 0; f < 3; f++) begin
            run_frame(VT, -1, HT, 1'b1, 0, bad);
            vectors++;
            if (bad !== 0) begin miscompares++; $display("FAIL %s_frame%0d: %0d cycles off, got %h want %h", tag, f, bad, bad_obs, bad_exp); end
            vectors++;
            if (locked !== (f == 2)) begin miscompares++; $display("FAIL %s_lock%0d: got %0d want %0d", tag, f, locked, f == 2); end
        end
    endtask

    task automatic test_nominal();
        clear_tally();
        relock("nominal");
        vectors++;
        if (err_count !== 8'd0) begin miscompares++; $display("FAIL nominal_errcnt: got %0d want 0", err_count); end
    endtask

    task automatic test_probe();
        int bad;
        clear_tally();
        run_frame(VT, -1, HT, 1'b1, 1, bad);
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL probe_frame: %0d cycles off, got %h want %h", bad, bad_obs, bad_exp); end
        vectors++;
        if (probe_bgr !== 24'h11448B) begin miscompares++; $display("FAIL probe_bgr: got %h want 11448b", probe_bgr); end
        vectors++;
        if (cnt_probe !== 1) begin miscompares++; $display("FAIL probe_stb_count: got %0d want 1", cnt_probe); end
        vectors++;
        if (cnt_valid !== HA * VA) begin miscompares++; $display("FAIL pix_valid_count: got %0d want %0d", cnt_valid, HA * VA); end
        vectors++;
        if (cnt_frame !== 1) begin miscompares++; $display("FAIL frame_stb_count: got %0d want 1", cnt_frame); end
    endtask

    task automatic test_h_stretch();
        int bad;
        clear_tally();
        run_frame(VT, 4, HT + 1, 1'b1, 0, bad);
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL hstretch_frame: %0d cycles off, got %h want %h", bad, bad_obs, bad_exp); end
        vectors++;
        if (cnt_herr !== 1) begin miscompares++; $display("FAIL hstretch_herr: got %0d want 1", cnt_herr); end
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL hstretch_locked: got %0d want 0", locked); end
        vectors++;
        if (err_count !== 8'd1) begin miscompares++; $display("FAIL hstretch_errcnt: got %0d want 1", err_count); end
        relock("hstretch_relock");
    endtask

    task automatic test_missing_hsync();
        int bad;
        clear_tally();
        run_frame(VT, 6, HT + 5, 1'b1, 0, bad);
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL nohs_frame: %0d cycles off, got %h want %h", bad, bad_obs, bad_exp); end
        vectors++;
        if (cnt_herr !== 1) begin miscompares++; $display("FAIL nohs_herr: got %0d want 1", cnt_herr); end
        vectors++;
        if (err_count !== 8'd2) begin miscompares++; $display("FAIL nohs_errcnt: got %0d want 2", err_count); end
        relock("nohs_relock");
    endtask

    task automatic test_v_errors();
        int bad, bad2;
        clear_tally();
        run_frame(VT - 1, -1, HT, 1'b1, 0, bad);
        run_frame(VT, -1, HT, 1'b1, 0, bad2);
        vectors++;
        if (bad + bad2 !== 0) begin miscompares++; $display("FAIL vshort_frames: %0d cycles off, got %h want %h", bad + bad2, bad_obs, bad_exp); end
        vectors++;
        if (cnt_verr !== 1 || cnt_herr !== 0) begin miscompares++; $display("FAIL vshort_pulses: got v%0d h%0d want v1 h0", cnt_verr, cnt_herr); end
        vectors++;
        if (err_count !== 8'd3) begin miscompares++; $display("FAIL vshort_errcnt: got %0d want 3", err_count); end
        relock("vshort_relock");
        clear_tally();
        run_frame(VT, -1, HT, 1'b0, 0, bad);
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL disp_frame: %0d cycles off, got %h want %h", bad, bad_obs, bad_exp); end
        vectors++;
        if (cnt_verr !== 1 || locked !== 1'b0) begin miscompares++; $display("FAIL disp_verr: got v%0d lock%0d want v1 lock0", cnt_verr, locked); end
        vectors++;
        if (err_count !== 8'd4) begin miscompares++; $display("FAIL disp_errcnt: got %0d want 4", err_count); end
        relock("disp_relock");
    endtask

    task automatic test_reset_mid();
        int bad;
        run_frame(VO + 4, -1, HT, 1'b1, 0, bad);
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL rstmid_partial: %0d cycles off, got %h want %h", bad, bad_obs, bad_exp); end
        #2 reset = 1;
        #1;
        vectors++;
        if (obs_vec !== 80'd0) begin miscompares++; $display("FAIL rstmid_async: got %h want 0", obs_vec); end
        HSYNC = 0; VSYNC = 0;
        repeat (2) @(posedge clk12);
        @(negedge clk12);
        reset = 0;
        model_reset();
        relock("rstmid_relock");
    endtask

`ifdef MON_FRAME_SIG_EN
    task automatic test_frame_sig();
        int bad, bad2;
        run_frame(VT, -1, HT, 1'b1, 2, bad);
        run_frame(VT, -1, HT, 1'b1, 3, bad2);
        vectors++;
        if (frame_sig !== 24'h0 || bad + bad2 !== 0) begin miscompares++; $display("FAIL sig_zero: got %h want 000000", frame_sig); end
        run_frame(VT, -1, HT, 1'b1, 2, bad);
        vectors++;
        if (frame_sig !== 24'h000001 || bad !== 0) begin miscompares++; $display("FAIL sig_single: got %h want 000001", frame_sig); end
    endtask
`endif

    task automatic test_back_to_back();
        int bad, kind, nl, ll, len;
        bit dsp;
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 6);
            nl = VT; ll = -1; len = HT; dsp = 1'b1;
            case (kind)
                3: begin ll = $urandom_range(0, VT - 1); len = HT - 3 + $urandom_range(0, 9); end
                4: nl = ($urandom_range(0, 1) == 0) ? VT - 1 : VT + 1;
                5: dsp = 1'b0;
                default: ;
            endcase
            run_frame(nl, ll, len, dsp, 0, bad);
            vectors++;
            if (bad !== 0) begin miscompares++; $display("FAIL b2b_frame%0d kind%0d: %0d cycles off, got %h want %h", f, kind, bad, bad_obs, bad_exp); end
        end
    endtask

    initial begin
        reset = 1; HSYNC = 0; VSYNC = 0; DISP = 0; BGR = 0;
        model_reset();
        clear_tally();
        test_reset();
        test_nominal();
        test_probe();
        test_h_stretch();
        test_missing_hsync();
        test_v_errors();
        test_reset_mid();
`ifdef MON_FRAME_SIG_EN
        test_frame_sig();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
